// File: rtl/if_id_buffer.sv
// ---------------------------------------------------------------------------
// if_id_buffer
//   Elastic two-entry skid buffer between instruction fetch and decode.
//   Fetch pushes {pc_m1, ir} through a valid/ready handshake. Decode pops the
//   head entry the same way. IF_READY depends only on registered occupancy, so
//   decode back-pressure never reaches fetch combinationally. FLUSH discards
//   every held entry, and any push offered in the same cycle, after a taken
//   branch or jump.
//
//   Optional feature macro: IFID_PERF_EN adds a saturating STALL_CNT output.
//
// Parameters
//   WIDTH      data path width of PC_M1 and IR
//   NOP_INSTR  instruction driven on ID_IR while the buffer is empty
//
// Ports
//   CLOCK      in   1      clock, rising edge
//   RESET_N    in   1      asynchronous active-low reset
//   IF_VALID   in   1      fetch offers IF_PC_M1/IF_IR
//   IF_READY   out  1      buffer can accept an entry (count != 2)
//   IF_PC_M1   in   WIDTH  PC+1 of fetched instruction
//   IF_IR      in   WIDTH  fetched instruction word
//   ID_VALID   out  1      head entry is valid (count != 0)
//   ID_READY   in   1      decode consumes the head entry
//   ID_PC_M1   out  WIDTH  head PC+1 (0 when empty)
//   ID_IR      out  WIDTH  head instruction (NOP_INSTR when empty)
//   FLUSH      in   1      synchronous discard of all entries
//   OCCUPANCY  out  2      number of held entries
//   STALL_CNT  out  16     (IFID_PERF_EN only) cycles fetch was refused
// ---------------------------------------------------------------------------
module if_id_buffer #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] NOP_INSTR = '0
) (
  input  logic             CLOCK,
  input  logic             RESET_N,
  input  logic             IF_VALID,
  output logic             IF_READY,
  input  logic [WIDTH-1:0] IF_PC_M1,
  input  logic [WIDTH-1:0] IF_IR,
  output logic             ID_VALID,
  input  logic             ID_READY,
  output logic [WIDTH-1:0] ID_PC_M1,
  output logic [WIDTH-1:0] ID_IR,
  input  logic             FLUSH,
  output logic [1:0]       OCCUPANCY
`ifdef IFID_PERF_EN
  ,
  output logic [15:0]      STALL_CNT
`endif
);

  // State encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] head_pc_q, head_pc_d;
  logic [WIDTH-1:0] head_ir_q, head_ir_d;
  logic [WIDTH-1:0] tail_pc_q, tail_pc_d;
  logic [WIDTH-1:0] tail_ir_q, tail_ir_d;
  logic             push;
  logic             pop;

  assign IF_READY  = (state_q != TWO);
  assign ID_VALID  = (state_q != EMPTY);
  assign OCCUPANCY = state_q;

  // The head register is reloaded with NOP/0 whenever the buffer empties,
  // so the decode-facing outputs come straight from flops with no muxing.
  assign ID_PC_M1 = head_pc_q;
  assign ID_IR    = head_ir_q;

  assign push = IF_VALID & IF_READY;
  assign pop  = ID_VALID & ID_READY;

  always_comb begin
    state_d   = state_q;
    head_pc_d = head_pc_q;
    head_ir_d = head_ir_q;
    tail_pc_d = tail_pc_q;
    tail_ir_d = tail_ir_q;
    if (FLUSH) begin
      state_d   = EMPTY;
      head_pc_d = '0;
      head_ir_d = NOP_INSTR;
    end else begin
      case (state_q)
        EMPTY: begin
          if (push) begin
            state_d   = ONE;
            head_pc_d = IF_PC_M1;
            head_ir_d = IF_IR;
          end
        end
        ONE: begin
          if (push && !pop) begin
            state_d   = TWO;
            tail_pc_d = IF_PC_M1;
            tail_ir_d = IF_IR;
          end else if (!push && pop) begin
            state_d   = EMPTY;
            head_pc_d = '0;
            head_ir_d = NOP_INSTR;
          end else if (push && pop) begin
            head_pc_d = IF_PC_M1;
            head_ir_d = IF_IR;
          end
        end
        TWO: begin
          // IF_READY is low here, so only a pop can happen.
          if (pop) begin
            state_d   = ONE;
            head_pc_d = tail_pc_q;
            head_ir_d = tail_ir_q;
          end
        end
        default: begin
          state_d   = EMPTY;
          head_pc_d = '0;
          head_ir_d = NOP_INSTR;
        end
      endcase
    end
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q   <= EMPTY;
      head_pc_q <= '0;
      head_ir_q <= NOP_INSTR;
      tail_pc_q <= '0;
      tail_ir_q <= '0;
    end else begin
      state_q   <= state_d;
      head_pc_q <= head_pc_d;
      head_ir_q <= head_ir_d;
      tail_pc_q <= tail_pc_d;
      tail_ir_q <= tail_ir_d;
    end
  end

`ifdef IFID_PERF_EN
  // Counts refused fetch offers; a flush cycle is not a stall.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      STALL_CNT <= '0;
    end else if (IF_VALID && !IF_READY && !FLUSH && (STALL_CNT != 16'hFFFF)) begin
      STALL_CNT <= STALL_CNT + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_id_buffer.sv
module tb_if_id_buffer;

  localparam int          WIDTH = 32;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        CLOCK = 1'b0;
  logic        RESET_N;
  logic        IF_VALID;
  logic        IF_READY;
  logic [31:0] IF_PC_M1;
  logic [31:0] IF_IR;
  logic        ID_VALID;
  logic        ID_READY;
  logic [31:0] ID_PC_M1;
  logic [31:0] ID_IR;
  logic        FLUSH;
  logic [1:0]  OCCUPANCY;
`ifdef IFID_PERF_EN
  logic [15:0] STALL_CNT;
`endif

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ir;
  } entry_t;

  entry_t      model_q[$];
  int unsigned stall_model;
  int          errors = 0;
  int          checks = 0;

  if_id_buffer #(.WIDTH(WIDTH), .NOP_INSTR(NOP)) dut (
    .CLOCK    (CLOCK),
    .RESET_N  (RESET_N),
    .IF_VALID (IF_VALID),
    .IF_READY (IF_READY),
    .IF_PC_M1 (IF_PC_M1),
    .IF_IR    (IF_IR),
    .ID_VALID (ID_VALID),
    .ID_READY (ID_READY),
    .ID_PC_M1 (ID_PC_M1),
    .ID_IR    (ID_IR),
    .FLUSH    (FLUSH),
    .OCCUPANCY(OCCUPANCY)
`ifdef IFID_PERF_EN
    ,
    .STALL_CNT(STALL_CNT)
`endif
  );

  always #5 CLOCK = ~CLOCK;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
    end
  endtask

  // Compare every observable output against the queue-based reference.
  task automatic checkAll();
    int n;
    n = model_q.size();
    checkOutput("id_valid",  64'(ID_VALID),  64'(n != 0));
    checkOutput("if_ready",  64'(IF_READY),  64'(n != 2));
    checkOutput("occupancy", 64'(OCCUPANCY), 64'(n));
    checkOutput("id_ir",     64'(ID_IR),     (n != 0) ? 64'(model_q[0].ir) : 64'(NOP));
    checkOutput("id_pc_m1",  64'(ID_PC_M1),  (n != 0) ? 64'(model_q[0].pc) : 64'd0);
`ifdef IFID_PERF_EN
    checkOutput("stall_cnt", 64'(STALL_CNT), 64'(stall_model));
`endif
  endtask

  // Drive one cycle of inputs, advance the reference across the edge, check.
  task automatic applyStimulus(input logic v, input logic [31:0] pc, input logic [31:0] ir,
                               input logic rdy, input logic fl);
    bit can_push;
    bit do_pop;
    IF_VALID = v;
    IF_PC_M1 = pc;
    IF_IR    = ir;
    ID_READY = rdy;
    FLUSH    = fl;
    @(posedge CLOCK);
    if (fl) begin
      model_q.delete();
    end else begin
      can_push = (model_q.size() < 2);
      do_pop   = (model_q.size() > 0) && rdy;
      if (v && !can_push && stall_model < 32'hFFFF) stall_model++;
      if (do_pop) void'(model_q.pop_front());
      if (v && can_push) model_q.push_back('{pc: pc, ir: ir});
    end
    #1;
    checkAll();
  endtask

  // Asynchronous reset asserted mid-cycle, checked before any clock edge.
  task automatic doReset();
    #2;
    IF_VALID = 1'b0;
    ID_READY = 1'b0;
    FLUSH    = 1'b0;
    RESET_N  = 1'b0;
    model_q.delete();
    stall_model = 0;
    #1;
    checkAll();
    @(posedge CLOCK);
    #1;
    checkAll();
    RESET_N = 1'b1;
  endtask

  initial begin
    RESET_N  = 1'b1;
    IF_VALID = 1'b0;
    IF_PC_M1 = '0;
    IF_IR    = '0;
    ID_READY = 1'b0;
    FLUSH    = 1'b0;
    stall_model = 0;
    @(posedge CLOCK);
    #1;
    doReset();

    // Fill to two entries, then reset mid-stream.
    applyStimulus(1, 32'h100, 32'hE1, 0, 0);
    applyStimulus(1, 32'h101, 32'hE2, 0, 0);
    checkOutput("full_before_reset", 64'(OCCUPANCY), 64'd2);
    doReset();

    // Streaming with decode always ready.
    applyStimulus(1, 32'h201, 32'hA1, 1, 0);
    applyStimulus(1, 32'h202, 32'hA2, 1, 0);
    applyStimulus(1, 32'h203, 32'hA3, 1, 0);
    checkOutput("stream_ir", 64'(ID_IR), 64'hA3);
    applyStimulus(0, 32'h0, 32'h0, 1, 0);

    // Back-pressure: B3 refused while full, re-offered after drain begins.
    applyStimulus(1, 32'h301, 32'hB1, 0, 0);
    applyStimulus(1, 32'h302, 32'hB2, 0, 0);
    applyStimulus(1, 32'h303, 32'hB3, 0, 0);
    checkOutput("bp_head", 64'(ID_IR), 64'hB1);
    applyStimulus(0, 32'h0, 32'h0, 1, 0);
    applyStimulus(1, 32'h303, 32'hB3, 1, 0);
    applyStimulus(0, 32'h0, 32'h0, 1, 0);
    applyStimulus(0, 32'h0, 32'h0, 1, 0);

    // Flush with a simultaneous push of C1.
    applyStimulus(1, 32'h401, 32'hC0, 0, 0);
    applyStimulus(1, 32'h402, 32'hC9, 0, 0);
    applyStimulus(1, 32'h403, 32'hC1, 0, 1);
    checkOutput("flush_ir", 64'(ID_IR), 64'(NOP));
    applyStimulus(0, 32'h0, 32'h0, 1, 0);

    // Simultaneous push and pop at count 1.
    applyStimulus(1, 32'h501, 32'hD1, 0, 0);
    applyStimulus(1, 32'h502, 32'hD2, 1, 0);
    checkOutput("pushpop_ir", 64'(ID_IR), 64'hD2);
    applyStimulus(0, 32'h0, 32'h0, 1, 0);

`ifdef IFID_PERF_EN
    doReset();
    applyStimulus(1, 32'h601, 32'hF1, 0, 0);
    applyStimulus(1, 32'h602, 32'hF2, 0, 0);
    for (int i = 0; i < 5; i++) applyStimulus(1, 32'h603, 32'hF3, 0, 0);
    checkOutput("stall_five", 64'(STALL_CNT), 64'd5);
    for (int i = 0; i < 70000; i++) applyStimulus(1, 32'h603, 32'hF3, 0, 0);
    checkOutput("stall_sat", 64'(STALL_CNT), 64'hFFFF);
    doReset();
`endif

    // Randomized traffic including flushes and occasional resets.
    for (int i = 0; i < 600; i++) begin
      if (i == 300) doReset();
      applyStimulus(($urandom % 4) != 0, $urandom, $urandom,
                    ($urandom % 3) != 0, ($urandom % 16) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
